// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator with a 2-entry skid buffer and a saturating illegal-opcode counter.
// Optional SYSTEM/Zicsr decode is enabled by defining IMM_GEN_ZICSR_EN.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [2:0]       fmt_out,
    output logic             illegal_out,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_SH   = 3'd6;
`ifdef IMM_GEN_ZICSR_EN
    localparam logic [2:0] FMT_Z    = 3'd7;
`endif

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [XLEN-1:0]   head_imm_q, head_imm_d, tail_imm_q, tail_imm_d;
    logic [2:0]        head_fmt_q, head_fmt_d, tail_fmt_q, tail_fmt_d;
    logic              head_ill_q, head_ill_d, tail_ill_q, tail_ill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              is_shift;
    logic [31:0]       dec_imm32;
    logic              dec_sext;
    logic [2:0]        dec_fmt;
    logic              dec_ill;
    logic [XLEN-1:0]   dec_imm;
    logic              accept;
    logic              deliver;

    assign opcode   = inst_code[6:0];
    assign funct3   = inst_code[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Decode works on a 32-bit immediate, widened to XLEN with the sign policy of its format.
    always_comb begin
        dec_imm32 = 32'd0;
        dec_sext  = 1'b1;
        dec_fmt   = FMT_NONE;
        dec_ill   = 1'b0;
        case (opcode)
            7'b0000011, 7'b1100111: begin
                dec_fmt   = FMT_I;
                dec_imm32 = {{20{inst_code[31]}}, inst_code[31:20]};
            end
            7'b0010011: begin
                if (is_shift) begin
                    dec_fmt  = FMT_SH;
                    dec_sext = 1'b0;
                    if (XLEN == 64) begin
                        dec_imm32 = {26'd0, inst_code[25:20]};
                    end else begin
                        dec_imm32 = {27'd0, inst_code[24:20]};
                        dec_ill   = inst_code[25];
                    end
                end else begin
                    dec_fmt   = FMT_I;
                    dec_imm32 = {{20{inst_code[31]}}, inst_code[31:20]};
                end
            end
            7'b0100011: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
            end
            7'b1100011: begin
                dec_fmt   = FMT_B;
                dec_imm32 = {{19{inst_code[31]}}, inst_code[31], inst_code[7],
                             inst_code[30:25], inst_code[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt   = FMT_U;
                dec_imm32 = {inst_code[31:12], 12'd0};
            end
            7'b1101111: begin
                dec_fmt   = FMT_J;
                dec_imm32 = {{11{inst_code[31]}}, inst_code[31], inst_code[19:12],
                             inst_code[20], inst_code[30:21], 1'b0};
            end
            7'b0110011, 7'b0001111: begin
                dec_fmt = FMT_NONE;
            end
            7'b0011011: begin
                if (XLEN != 64) begin
                    dec_ill = 1'b1;
                end else if (is_shift) begin
                    dec_fmt   = FMT_SH;
                    dec_sext  = 1'b0;
                    dec_imm32 = {27'd0, inst_code[24:20]};
                    dec_ill   = inst_code[25];
                end else begin
                    dec_fmt   = FMT_I;
                    dec_imm32 = {{20{inst_code[31]}}, inst_code[31:20]};
                end
            end
            7'b0111011: begin
                dec_ill = (XLEN != 64);
            end
`ifdef IMM_GEN_ZICSR_EN
            7'b1110011: begin
                dec_sext = 1'b0;
                case (funct3)
                    3'b101, 3'b110, 3'b111: begin
                        dec_fmt   = FMT_Z;
                        dec_imm32 = {27'd0, inst_code[19:15]};
                    end
                    3'b001, 3'b010, 3'b011: begin
                        dec_fmt   = FMT_I;
                        dec_imm32 = {20'd0, inst_code[31:20]};
                    end
                    3'b000:  dec_fmt = FMT_NONE;
                    default: dec_ill = 1'b1;
                endcase
            end
`endif
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_imm32 = 32'd0;
            dec_fmt   = FMT_NONE;
        end
        dec_imm = dec_sext ? XLEN'($signed(dec_imm32)) : XLEN'(dec_imm32);
    end

    assign out_valid = (state_q != S_EMPTY);
    assign accept    = in_valid && in_ready_q;
    assign deliver   = out_valid && out_ready;

    // Head entry drives the outputs; tail only fills when the consumer stalls with the head occupied.
    always_comb begin
        state_d    = state_q;
        head_imm_d = head_imm_q;
        head_fmt_d = head_fmt_q;
        head_ill_d = head_ill_q;
        tail_imm_d = tail_imm_q;
        tail_fmt_d = tail_fmt_q;
        tail_ill_d = tail_ill_q;
        cnt_d      = cnt_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            if (accept && dec_ill && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        head_imm_d = dec_imm;
                        head_fmt_d = dec_fmt;
                        head_ill_d = dec_ill;
                        state_d    = S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && deliver) begin
                        head_imm_d = dec_imm;
                        head_fmt_d = dec_fmt;
                        head_ill_d = dec_ill;
                    end else if (accept) begin
                        tail_imm_d = dec_imm;
                        tail_fmt_d = dec_fmt;
                        tail_ill_d = dec_ill;
                        state_d    = S_TWO;
                    end else if (deliver) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (deliver) begin
                        head_imm_d = tail_imm_q;
                        head_fmt_d = tail_fmt_q;
                        head_ill_d = tail_ill_q;
                        state_d    = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
        in_ready_d = (state_d != S_TWO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
            head_imm_q <= '0;
            head_fmt_q <= FMT_NONE;
            head_ill_q <= 1'b0;
            tail_imm_q <= '0;
            tail_fmt_q <= FMT_NONE;
            tail_ill_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_imm_q <= head_imm_d;
            head_fmt_q <= head_fmt_d;
            head_ill_q <= head_ill_d;
            tail_imm_q <= tail_imm_d;
            tail_fmt_q <= tail_fmt_d;
            tail_ill_q <= tail_ill_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign imm_out     = head_imm_q;
    assign fmt_out     = head_fmt_q;
    assign illegal_out = head_ill_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32/CNT_W=4 and one XLEN=64/CNT_W=16 instance fed the same stream.
module tb_imm_gen_pipe;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] inst_code;
    logic        out_ready;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [3:0]  cnt32;

    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [15:0] cnt64;

    int check_count = 0;
    int error_count = 0;

    imm_gen_pipe #(.XLEN(32), .CNT_W(4)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .inst_code(inst_code),
        .out_valid(out_valid32), .out_ready(out_ready),
        .imm_out(imm32), .fmt_out(fmt32), .illegal_out(illegal32), .illegal_cnt(cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .inst_code(inst_code),
        .out_valid(out_valid64), .out_ready(out_ready),
        .imm_out(imm64), .fmt_out(fmt64), .illegal_out(illegal64), .illegal_cnt(cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the edge so outputs can be sampled.
    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic ordy, input logic fl);
        in_valid  = v;
        inst_code = inst;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " ov32"},  {63'd0, out_valid32}, 64'd0);
        checkOutput({tag, " ir32"},  {63'd0, in_ready32},  64'd1);
        checkOutput({tag, " imm32"}, {32'd0, imm32},       64'd0);
        checkOutput({tag, " fmt32"}, {61'd0, fmt32},       64'd0);
        checkOutput({tag, " ill32"}, {63'd0, illegal32},   64'd0);
        checkOutput({tag, " cnt32"}, {60'd0, cnt32},       64'd0);
        checkOutput({tag, " ov64"},  {63'd0, out_valid64}, 64'd0);
        checkOutput({tag, " imm64"}, imm64,                64'd0);
        checkOutput({tag, " cnt64"}, {48'd0, cnt64},       64'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; inst_code = 32'd0; out_ready = 1'b1;
        applyStimulus(0, 32'd0, 1, 0);
        applyStimulus(0, 32'd0, 1, 0);
        checkResetState("reset");
        reset = 1'b0;

        // ADDI x1,x0,-1
        applyStimulus(1, 32'hFFF0_0093, 1, 0);
        checkOutput("addi ov",    {63'd0, out_valid32}, 64'd1);
        checkOutput("addi imm32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFF);
        checkOutput("addi fmt",   {61'd0, fmt32}, 64'd1);
        checkOutput("addi ill",   {63'd0, illegal32}, 64'd0);
        checkOutput("addi imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);

        // BEQ then LUI back to back, consumer always ready
        applyStimulus(1, 32'h8000_0063, 1, 0);
        checkOutput("beq imm64", imm64, 64'hFFFF_FFFF_FFFF_F000);
        checkOutput("beq fmt64", {61'd0, fmt64}, 64'd3);
        checkOutput("beq imm32", {32'd0, imm32}, 64'h0000_0000_FFFF_F000);
        applyStimulus(1, 32'h8000_00B7, 1, 0);
        checkOutput("lui imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        checkOutput("lui fmt64", {61'd0, fmt64}, 64'd4);
        checkOutput("lui imm32", {32'd0, imm32}, 64'h0000_0000_8000_0000);
        applyStimulus(0, 32'd0, 1, 0);
        checkOutput("drain ov", {63'd0, out_valid32}, 64'd0);

        // Backpressure: JAL then SW with the consumer stalled
        applyStimulus(1, 32'h0080_006F, 0, 0);
        checkOutput("jal imm",  {32'd0, imm32}, 64'd8);
        checkOutput("jal fmt",  {61'd0, fmt32}, 64'd5);
        checkOutput("jal ir",   {63'd0, in_ready32}, 64'd1);
        applyStimulus(1, 32'h0011_2623, 0, 0);
        checkOutput("two ir32", {63'd0, in_ready32}, 64'd0);
        checkOutput("two ir64", {63'd0, in_ready64}, 64'd0);
        checkOutput("two imm",  {32'd0, imm32}, 64'd8);
        applyStimulus(0, 32'd0, 0, 0);
        checkOutput("hold imm", {32'd0, imm32}, 64'd8);
        checkOutput("hold fmt", {61'd0, fmt32}, 64'd5);
        applyStimulus(0, 32'd0, 1, 0);
        checkOutput("sw ov",  {63'd0, out_valid32}, 64'd1);
        checkOutput("sw imm", {32'd0, imm32}, 64'd12);
        checkOutput("sw fmt", {61'd0, fmt32}, 64'd2);
        checkOutput("sw ir",  {63'd0, in_ready32}, 64'd1);
        applyStimulus(0, 32'd0, 1, 0);
        checkOutput("empty ov", {63'd0, out_valid32}, 64'd0);

        // SLLI with inst[25]=1: illegal on RV32, shamt 32 on RV64
        applyStimulus(1, 32'h0200_9093, 1, 0);
        checkOutput("slli ill32", {63'd0, illegal32}, 64'd1);
        checkOutput("slli imm32", {32'd0, imm32}, 64'd0);
        checkOutput("slli fmt32", {61'd0, fmt32}, 64'd0);
        checkOutput("slli cnt32", {60'd0, cnt32}, 64'd1);
        checkOutput("slli ill64", {63'd0, illegal64}, 64'd0);
        checkOutput("slli imm64", imm64, 64'd32);
        checkOutput("slli fmt64", {61'd0, fmt64}, 64'd6);
        checkOutput("slli cnt64", {48'd0, cnt64}, 64'd0);

        // Opcode 0x7F pushed 19 times: 4-bit counter saturates, 16-bit one keeps counting
        for (int i = 0; i < 19; i++) applyStimulus(1, 32'h0000_007F, 1, 0);
        checkOutput("sat cnt32", {60'd0, cnt32}, 64'd15);
        checkOutput("sat cnt64", {48'd0, cnt64}, 64'd19);
        checkOutput("sat ill",   {63'd0, illegal32}, 64'd1);
        applyStimulus(0, 32'd0, 1, 0);

        // Flush in TWO with in_valid high
        applyStimulus(1, 32'hFFF0_0093, 0, 0);
        applyStimulus(1, 32'h8000_00B7, 0, 0);
        checkOutput("pre-flush ir", {63'd0, in_ready32}, 64'd0);
        applyStimulus(1, 32'h0000_007F, 0, 1);
        checkOutput("flush2 ov",  {63'd0, out_valid32}, 64'd0);
        checkOutput("flush2 ir",  {63'd0, in_ready32}, 64'd1);
        checkOutput("flush2 cnt", {48'd0, cnt64}, 64'd19);

        // Flush in ONE: the same-cycle illegal accept is dropped and not counted
        applyStimulus(1, 32'hFFF0_0093, 0, 0);
        applyStimulus(1, 32'h0000_007F, 0, 1);
        checkOutput("flush1 ov",  {63'd0, out_valid64}, 64'd0);
        checkOutput("flush1 cnt", {48'd0, cnt64}, 64'd19);

        // Reset mid-stream wins over a pending accept
        applyStimulus(1, 32'hFFF0_0093, 0, 0);
        reset = 1'b1;
        applyStimulus(1, 32'h0000_007F, 0, 0);
        checkResetState("midreset");
        reset = 1'b0;

        // ADD: legal, no immediate
        applyStimulus(1, 32'h0000_0033, 1, 0);
        checkOutput("add ov",  {63'd0, out_valid32}, 64'd1);
        checkOutput("add fmt", {61'd0, fmt32}, 64'd0);
        checkOutput("add ill", {63'd0, illegal32}, 64'd0);

        // CSRRWI x0, mscratch, 3
        applyStimulus(1, 32'h3401_D073, 1, 0);
`ifdef IMM_GEN_ZICSR_EN
        checkOutput("csrrwi fmt", {61'd0, fmt32}, 64'd7);
        checkOutput("csrrwi imm", {32'd0, imm32}, 64'd3);
        checkOutput("csrrwi ill", {63'd0, illegal32}, 64'd0);
        checkOutput("csrrwi cnt", {60'd0, cnt32}, 64'd0);
`else
        checkOutput("csrrwi ill", {63'd0, illegal32}, 64'd1);
        checkOutput("csrrwi fmt", {61'd0, fmt32}, 64'd0);
        checkOutput("csrrwi imm", {32'd0, imm32}, 64'd0);
        checkOutput("csrrwi cnt", {60'd0, cnt32}, 64'd1);
`endif
        applyStimulus(0, 32'd0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
